// File: rtl/traffic_light_monitor_if.sv
// Bus between the traffic-light controller output and its passive monitor.
// The master drives the light code; the slave (monitor) returns the decoded status.
interface traffic_light_monitor_if #(
   parameter int unsigned DW = 32
) ();
   logic [2:0]    light;
   logic [1:0]    phase;
   logic          phase_valid;
   logic [DW-1:0] dwell;
   logic          err_seq;
   logic          err_time;
   logic          err_code;
   logic          err_sticky;
   logic [15:0]   cycle_count;

   modport master (
      output light,
      input  phase, phase_valid, dwell, err_seq, err_time, err_code, err_sticky, cycle_count
   );

   modport slave (
      input  light,
      output phase, phase_valid, dwell, err_seq, err_time, err_code, err_sticky, cycle_count
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive traffic-light monitor: decodes the light bus into phases and checks
// phase order, per-phase dwell time and code legality.
module traffic_light_monitor #(
   parameter int unsigned CLK_FREQ    = 1,
   parameter int unsigned RED_S       = 60,
   parameter int unsigned RED_AMBER_S = 2,
   parameter int unsigned GREEN_S     = 50,
   parameter int unsigned AMBER_S     = 3,
   parameter int unsigned TOL         = 0,
   parameter int unsigned DW          = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   traffic_light_monitor_if.slave   io
);

   typedef enum logic [1:0] {
      PH_RED       = 2'd0,
      PH_RED_AMBER = 2'd1,
      PH_GREEN     = 2'd2,
      PH_AMBER     = 2'd3
   } phase_t;

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // 64-bit arithmetic so board-rate CLK_FREQ products do not overflow
   localparam logic [63:0] E_RED       = 64'(RED_S)       * 64'(CLK_FREQ) + 64'd1;
   localparam logic [63:0] E_RED_AMBER = 64'(RED_AMBER_S) * 64'(CLK_FREQ) + 64'd1;
   localparam logic [63:0] E_GREEN     = 64'(GREEN_S)     * 64'(CLK_FREQ) + 64'd1;
   localparam logic [63:0] E_AMBER     = 64'(AMBER_S)     * 64'(CLK_FREQ) + 64'd1;
   localparam logic [63:0] TOL64       = 64'(TOL);

   function automatic logic [63:0] f_exp(input phase_t p);
      case (p)
         PH_RED:       return E_RED;
         PH_RED_AMBER: return E_RED_AMBER;
         PH_GREEN:     return E_GREEN;
         default:      return E_AMBER;
      endcase
   endfunction

   state_t        r_state;
   phase_t        r_phase;
   logic          r_phase_valid;
   logic [2:0]    r_cur;
   logic [DW-1:0] r_dwell;
   logic          r_timed_out;
   logic          r_err_seq;
   logic          r_err_time;
   logic          r_err_code;
   logic          r_err_sticky;
   logic [15:0]   r_cycle_count;

   logic          w_defined;
   phase_t        w_dec;
   logic          w_change;
   logic [DW-1:0] w_dwell_inc;
   logic [63:0]   w_exp;
   logic [63:0]   w_lo;
   logic [63:0]   w_hi;
   logic [63:0]   w_d64;
   logic [63:0]   w_inc64;

   always_comb begin
      w_defined = 1'b1;
      w_dec     = PH_RED;
      case (io.light)
         3'b100:  w_dec = PH_RED;
         3'b110:  w_dec = PH_RED_AMBER;
         3'b001:  w_dec = PH_GREEN;
         3'b010:  w_dec = PH_AMBER;
         default: w_defined = 1'b0;
      endcase
   end

   always_comb begin
      w_change    = (io.light != r_cur);
      w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + DW'(1);
      w_exp       = f_exp(r_phase);
      // Lower bound clamps to 1 when the tolerance swallows the whole window
      w_lo        = (w_exp > TOL64) ? (w_exp - TOL64) : 64'd1;
      w_hi        = w_exp + TOL64;
      w_d64       = 64'(r_dwell);
      w_inc64     = 64'(w_dwell_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_SYNC;
         r_phase       <= PH_RED;
         r_phase_valid <= 1'b0;
         r_cur         <= '0;
         r_dwell       <= '0;
         r_timed_out   <= 1'b0;
         r_err_seq     <= 1'b0;
         r_err_time    <= 1'b0;
         r_err_code    <= 1'b0;
         r_err_sticky  <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         r_err_seq  <= 1'b0;
         r_err_time <= 1'b0;
         r_err_code <= 1'b0;

         if (w_change) begin
            r_cur   <= io.light;
            r_dwell <= DW'(1);
         end else begin
            r_dwell <= w_dwell_inc;
         end

         case (r_state)
            ST_SYNC: begin
               if (w_change && w_defined) begin
                  r_state       <= ST_LOCKED;
                  r_phase       <= w_dec;
                  r_phase_valid <= 1'b1;
                  r_timed_out   <= 1'b0;
               end
            end
            default: begin
               // A locked cur is always defined, so an undefined sample is always a change
               if (!w_defined) begin
                  r_err_code    <= 1'b1;
                  r_err_sticky  <= 1'b1;
                  r_state       <= ST_SYNC;
                  r_phase_valid <= 1'b0;
               end else if (w_change) begin
                  if (w_dec != phase_t'(r_phase + 2'd1)) begin
                     r_err_seq     <= 1'b1;
                     r_err_sticky  <= 1'b1;
                     r_state       <= ST_SYNC;
                     r_phase_valid <= 1'b0;
                  end else begin
                     if (!r_timed_out && ((w_d64 < w_lo) || (w_d64 > w_hi))) begin
                        r_err_time   <= 1'b1;
                        r_err_sticky <= 1'b1;
                     end
                     r_phase     <= w_dec;
                     r_timed_out <= 1'b0;
                     if (r_phase == PH_AMBER)
                        r_cycle_count <= r_cycle_count + 16'd1;
                  end
               end else if (!r_timed_out && (w_inc64 == w_hi + 64'd1)) begin
                  r_err_time   <= 1'b1;
                  r_err_sticky <= 1'b1;
                  r_timed_out  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign io.phase       = r_phase;
   assign io.phase_valid = r_phase_valid;
   assign io.dwell       = r_dwell;
   assign io.err_seq     = r_err_seq;
   assign io.err_time    = r_err_time;
   assign io.err_code    = r_err_code;
   assign io.err_sticky  = r_err_sticky;
   assign io.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: nominal sequences, skipped phase,
// short dwell, stuck light, glitch code and asynchronous reset.
module tb_traffic_light_monitor;

   logic clk;
   logic rst_n;

   traffic_light_monitor_if #(.DW(32)) io ();

   traffic_light_monitor #(
      .CLK_FREQ    (1),
      .RED_S       (60),
      .RED_AMBER_S (2),
      .GREEN_S     (50),
      .AMBER_S     (3),
      .TOL         (0),
      .DW          (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   localparam logic [2:0] C_RED   = 3'b100;
   localparam logic [2:0] C_RA    = 3'b110;
   localparam logic [2:0] C_GREEN = 3'b001;
   localparam logic [2:0] C_AMBER = 3'b010;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_fail = 0;
   int unsigned n_errs = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One sample: present code, let the next rising edge take it, look 1 ns later
   task automatic step(input logic [2:0] code);
      io.light = code;
      @(posedge clk);
      #1;
      if (io.err_seq || io.err_time || io.err_code) n_errs++;
   endtask

   task automatic hold(input logic [2:0] code, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(code);
   endtask

   int unsigned n_tpulse;
   logic [31:0] d_at_pulse;

   initial begin
      rst_n    = 1'b0;
      io.light = C_RED;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 64'(io.phase_valid), 64'd0);
      chk("reset_dwell", 64'(io.dwell), 64'd0);
      chk("reset_flags", 64'({io.err_seq, io.err_time, io.err_code, io.err_sticky}), 64'd0);
      chk("reset_count", 64'(io.cycle_count), 64'd0);
      #3 rst_n = 1'b1;

      // Nominal: first RED sample leaves the reset code 000 and locks
      n_errs = 0;
      step(C_RED);
      chk("lock_valid", 64'(io.phase_valid), 64'd1);
      chk("lock_phase", 64'(io.phase), 64'd0);
      chk("lock_dwell", 64'(io.dwell), 64'd1);
      hold(C_RED, 60);
      chk("peak_red", 64'(io.dwell), 64'd61);
      hold(C_RA, 3);
      chk("peak_ra", 64'(io.dwell), 64'd3);
      hold(C_GREEN, 51);
      chk("peak_green", 64'(io.dwell), 64'd51);
      hold(C_AMBER, 4);
      chk("peak_amber", 64'(io.dwell), 64'd4);
      chk("phase_amber", 64'(io.phase), 64'd3);
      for (int k = 0; k < 2; k++) begin
         hold(C_RED, 61);
         hold(C_RA, 3);
         hold(C_GREEN, 51);
         hold(C_AMBER, 4);
      end
      chk("count_before_third", 64'(io.cycle_count), 64'd2);
      step(C_RED);
      chk("count_three", 64'(io.cycle_count), 64'd3);
      chk("nominal_no_errs", 64'(n_errs), 64'd0);
      chk("nominal_sticky", 64'(io.err_sticky), 64'd0);

      // Skipped phase: GREEN straight to RED
      hold(C_RED, 60);
      hold(C_RA, 3);
      hold(C_GREEN, 51);
      step(C_RED);
      chk("skip_err_seq", 64'(io.err_seq), 64'd1);
      chk("skip_valid", 64'(io.phase_valid), 64'd0);
      chk("skip_sticky", 64'(io.err_sticky), 64'd1);
      chk("skip_count", 64'(io.cycle_count), 64'd3);
      step(C_RED);
      chk("skip_seq_one_cycle", 64'(io.err_seq), 64'd0);
      step(C_RA);
      chk("relock_valid", 64'(io.phase_valid), 64'd1);
      chk("relock_phase", 64'(io.phase), 64'd1);
      chk("relock_err_time", 64'(io.err_time), 64'd0);

      // Short GREEN dwell of 40
      hold(C_RA, 2);
      n_errs = 0;
      hold(C_GREEN, 40);
      chk("short_quiet_green", 64'(n_errs), 64'd0);
      step(C_AMBER);
      chk("short_err_time", 64'(io.err_time), 64'd1);
      chk("short_valid", 64'(io.phase_valid), 64'd1);
      chk("short_phase", 64'(io.phase), 64'd3);
      step(C_AMBER);
      chk("short_one_cycle", 64'(io.err_time), 64'd0);
      hold(C_AMBER, 2);

      // Stuck RED for 100 samples
      n_tpulse   = 0;
      d_at_pulse = '0;
      n_errs     = 0;
      for (int unsigned i = 0; i < 100; i++) begin
         step(C_RED);
         if (io.err_time) begin
            n_tpulse++;
            d_at_pulse = io.dwell;
         end
      end
      chk("stuck_count_cycles", 64'(io.cycle_count), 64'd4);
      chk("stuck_pulses", 64'(n_tpulse), 64'd1);
      chk("stuck_dwell_at_pulse", 64'(d_at_pulse), 64'd62);
      chk("stuck_other_errs", 64'(n_errs), 64'd1);
      step(C_RA);
      chk("stuck_change_no_pulse", 64'(io.err_time), 64'd0);
      chk("stuck_phase", 64'(io.phase), 64'd1);
      chk("stuck_valid", 64'(io.phase_valid), 64'd1);

      // Glitch 111 inside GREEN
      hold(C_RA, 2);
      hold(C_GREEN, 10);
      step(3'b111);
      chk("glitch_err_code", 64'(io.err_code), 64'd1);
      chk("glitch_valid", 64'(io.phase_valid), 64'd0);
      n_errs = 0;
      step(C_GREEN);
      chk("glitch_code_one_cycle", 64'(io.err_code), 64'd0);
      chk("glitch_relock_valid", 64'(io.phase_valid), 64'd1);
      chk("glitch_relock_phase", 64'(io.phase), 64'd2);
      chk("glitch_relock_dwell", 64'(io.dwell), 64'd1);
      hold(C_GREEN, 50);
      step(C_AMBER);
      chk("glitch_no_err_time", 64'(n_errs), 64'd0);

      // Asynchronous reset between edges in GREEN
      hold(C_AMBER, 3);
      hold(C_RED, 61);
      hold(C_RA, 3);
      hold(C_GREEN, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_valid", 64'(io.phase_valid), 64'd0);
      chk("areset_phase", 64'(io.phase), 64'd0);
      chk("areset_dwell", 64'(io.dwell), 64'd0);
      chk("areset_flags", 64'({io.err_seq, io.err_time, io.err_code, io.err_sticky}), 64'd0);
      chk("areset_count", 64'(io.cycle_count), 64'd0);
      io.light = 3'b000;
      @(posedge clk);
      #3 rst_n = 1'b1;
      n_errs = 0;
      hold(3'b000, 3);
      chk("post_reset_sync", 64'(io.phase_valid), 64'd0);
      step(3'b111);
      chk("post_reset_undef_ignored", 64'(io.phase_valid), 64'd0);
      step(C_GREEN);
      chk("post_reset_lock_phase", 64'(io.phase), 64'd2);
      chk("post_reset_lock_valid", 64'(io.phase_valid), 64'd1);
      chk("post_reset_no_errs", 64'(n_errs), 64'd0);
      chk("post_reset_sticky", 64'(io.err_sticky), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
